// File: rtl/step_pkg.sv
// step_pkg: step command codes and scheduler FSM states, shared with the display FSM.
package step_pkg;
  typedef enum logic [1:0] {CMD_HOLD = 2'b00, CMD_DOWN = 2'b01, CMD_UP = 2'b10, CMD_OFF = 2'b11} step_cmd_e;
  typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, HOLDOFF = 2'b10} sched_state_e;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: base-tick prescaler and 2**rate_sel auto-run period counter.
module tick_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [1:0] rate_sel,
  output logic       tick,
  output logic       auto_fire
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  logic [2:0] per_cnt, per_last;
  logic [1:0] per_sel;
  logic wrap, fire;
  assign wrap = cnt == CW'(DIV - 1);
  assign per_last = 3'((4'd1 << per_sel) - 4'd1);
  assign fire = wrap && per_cnt == per_last;
  // rate_sel is only taken at a period wrap so a change never truncates the running period
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      cnt       <= '0;
      per_cnt   <= '0;
      per_sel   <= '0;
      tick      <= 1'b0;
      auto_fire <= 1'b0;
    end else begin
      cnt       <= wrap ? '0 : cnt + 1'b1;
      per_cnt   <= fire ? '0 : wrap ? per_cnt + 1'b1 : per_cnt;
      per_sel   <= fire ? rate_sel : per_sel;
      tick      <= wrap;
      auto_fire <= fire;
    end
endmodule

// File: rtl/step_scheduler.sv
// step_scheduler: arbitrates manual switch edges and auto-run into valid/ready step commands.
module step_scheduler
  import step_pkg::*;
#(
  parameter int DIV           = 50_000_000,
  parameter int HOLDOFF_TICKS = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       sw_up,
  input  logic       sw_down,
  input  logic       auto_en,
  input  logic       auto_dir,
  input  logic [1:0] rate_sel,
  input  logic       step_ready,
  output logic       step_valid,
  output logic [1:0] step_cmd,
  output logic       tick,
  output logic       grant_manual,
  output logic       overrun
);
  localparam int HW = HOLDOFF_TICKS > 1 ? $clog2(HOLDOFF_TICKS + 1) : 1;
  localparam logic [HW-1:0] HO_LAST = HW'(HOLDOFF_TICKS - 1);
  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic [1:0] rate_s;
  logic up_s, down_s, en_s, dir_s, up_d, down_d;
  logic rise, auto_fire, auto_req, grant_m, grant_a, man_q, pend;
  logic [HW-1:0] ho_cnt;
  step_cmd_e new_cmd, pend_cmd, cmd_q;
  sched_state_e state, state_d;
  assign {rate_s, dir_s, en_s, down_s, up_s} = sync_q[SYNC_STAGES-1];
  assign rise = (up_s & ~up_d) | (down_s & ~down_d);
  assign new_cmd = up_s & down_s ? CMD_OFF : up_s ? CMD_UP : CMD_DOWN;
  assign auto_req = auto_fire & en_s;
  tick_gen #(.DIV(DIV)) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .rate_sel (rate_s),
    .tick     (tick),
    .auto_fire(auto_fire)
  );
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) state <= IDLE;
    else state <= state_d;
  // manual always outranks auto; a pending manual edge also cuts the holdoff short
  always_comb begin
    state_d = state;
    grant_m = 1'b0;
    grant_a = 1'b0;
    case (state)
      IDLE: begin
        grant_m = pend;
        grant_a = ~pend & auto_req;
        state_d = pend | auto_req ? ISSUE : IDLE;
      end
      ISSUE: state_d = step_ready ? (man_q ? HOLDOFF : IDLE) : ISSUE;
      HOLDOFF: begin
        grant_m = pend;
        state_d = pend ? ISSUE : tick && ho_cnt == HO_LAST ? IDLE : HOLDOFF;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    step_valid   = state == ISSUE;
    step_cmd     = step_valid ? cmd_q : CMD_HOLD;
    grant_manual = step_valid & man_q;
  end
  // a fresh edge in the grant cycle stays pending rather than being swallowed by the clear
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      sync_q   <= '0;
      up_d     <= 1'b0;
      down_d   <= 1'b0;
      pend     <= 1'b0;
      pend_cmd <= CMD_HOLD;
      cmd_q    <= CMD_HOLD;
      man_q    <= 1'b0;
      ho_cnt   <= '0;
      overrun  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], {rate_sel, auto_dir, auto_en, sw_down, sw_up}};
      up_d     <= up_s;
      down_d   <= down_s;
      pend     <= rise | (pend & ~grant_m);
      pend_cmd <= rise ? new_cmd : pend_cmd;
      cmd_q    <= grant_m ? pend_cmd : grant_a ? (dir_s ? CMD_UP : CMD_DOWN) : cmd_q;
      man_q    <= grant_m | (man_q & ~grant_a);
      ho_cnt   <= state != HOLDOFF ? '0 : tick ? ho_cnt + 1'b1 : ho_cnt;
      overrun  <= overrun | (state == ISSUE & auto_req);
    end
endmodule
